// File: rtl/keys_edge_pio.sv
// Avalon-MM input PIO: synchronized key/switch lines, sticky edge capture,
// maskable level interrupt. Standard PIO register layout, zero read latency.
module keys_edge_pio #(
    parameter int WIDTH       = 4,
    parameter int EDGE_TYPE   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] PRIME_LOAD = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] det;
    logic [WIDTH-1:0] clr;
    logic [CNT_W-1:0] prime_cnt;
    logic             irq_q;
    logic             wr_en;
    logic             unused_wd;

    assign sync_q    = sync_p[SYNC_STAGES-1];
    assign wr_en     = chipselect && !write_n;
    assign clr       = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign irq       = irq_q;
    assign unused_wd = ^writedata;

    // Synchronizer chain and one-cycle history for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_p[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
            prev_q <= sync_q;
        end
    end

    // Detection is held off until the chain and history hold post-reset samples
    always_comb begin
        det = '0;
        case (EDGE_TYPE)
            0:       det = sync_q & ~prev_q;
            1:       det = ~sync_q & prev_q;
            default: det = sync_q ^ prev_q;
        endcase
        if (prime_cnt != '0) begin
            det = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_cnt <= PRIME_LOAD;
            edge_cap  <= '0;
            irq_mask  <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (prime_cnt != '0) begin
                prime_cnt <= prime_cnt - 1'b1;
            end
            // A detect wins over a simultaneous clear so no edge is lost
            edge_cap <= (edge_cap & ~clr) | det;
            if (wr_en && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            irq_q <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = sync_q;
            2'd2:    readdata[WIDTH-1:0] = irq_mask;
            2'd3:    readdata[WIDTH-1:0] = edge_cap;
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_keys_edge_pio.sv
// Bench for keys_edge_pio: three instances (rising, falling, any edge) against
// a history-based reference model, plus directed register-level scenarios.
module tb_keys_edge_pio;

    localparam int W = 4;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [W-1:0] in_port = '0;
    logic [31:0] rd [3];
    logic [2:0]  irqv;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    keys_edge_pio #(.WIDTH(W), .EDGE_TYPE(0), .SYNC_STAGES(S)) u_rise (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[0]), .irq(irqv[0]));
    keys_edge_pio #(.WIDTH(W), .EDGE_TYPE(1), .SYNC_STAGES(S)) u_fall (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[1]), .irq(irqv[1]));
    keys_edge_pio #(.WIDTH(W), .EDGE_TYPE(2), .SYNC_STAGES(S)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd[2]), .irq(irqv[2]));

    // Reference model: log of in_port samples taken at each edge since reset
    int           k;
    logic [W-1:0] log_q [$];
    logic [W-1:0] m_cap [3];
    logic [W-1:0] m_mask;
    logic         m_irq [3];

    function automatic logic [W-1:0] m_data();
        return (k >= S) ? log_q[k-S] : '0;
    endfunction

    function automatic logic [31:0] exp_rd(int t, logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_data());
            2'd2:    return 32'(m_mask);
            2'd3:    return 32'(m_cap[t]);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [W-1:0] cur, old, clr, det;
        if (reset) begin
            k = 0;
            log_q.delete();
            m_mask = '0;
            for (int t = 0; t < 3; t++) begin
                m_cap[t] = '0;
                m_irq[t] = 1'b0;
            end
        end else begin
            cur = m_data();
            old = (k >= S + 1) ? log_q[k-S-1] : '0;
            clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
            for (int t = 0; t < 3; t++) begin
                m_irq[t] = |(m_cap[t] & m_mask);
                det = '0;
                for (int b = 0; b < W; b++) begin
                    if (k >= S + 1 && cur[b] != old[b] &&
                        (t == 2 || (t == 0 && cur[b]) || (t == 1 && !cur[b])))
                        det[b] = 1'b1;
                end
                m_cap[t] = (m_cap[t] & ~clr) | det;
            end
            if (chipselect && !write_n && address == 2'd2)
                m_mask = writedata[W-1:0];
            log_q.push_back(in_port);
            k++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        for (int t = 0; t < 3; t++) begin
            check($sformatf("model_rd%0d_a%0d", t, address), rd[t], exp_rd(t, address));
            check($sformatf("model_irq%0d", t), 32'(irqv[t]), 32'(m_irq[t]));
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (chk_en) chk_all();
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic peek(input logic [1:0] a);
        address = a;
        #1;
        if (chk_en) chk_all();
    endtask

    initial begin
        // Lines high through reset: priming must suppress the release edge
        in_port = 4'hF;
        reset   = 1'b1;
        step(3);
        chk_en = 1'b1;
        reset  = 1'b0;
        step(10);
        peek(2'd3);
        check("prime_cap_rise", rd[0], 32'h0);
        check("prime_cap_any", rd[2], 32'h0);
        check("prime_irq", 32'(irqv), 32'h0);
        peek(2'd0);
        check("data_after_reset", rd[0], 32'h0000000F);

        // Falling edge on bit1, masked in
        do_write(2'd2, 32'h2);
        in_port = 4'hD;
        address = 2'd0;
        step(2);
        check("data_bit1_low", rd[1], 32'h0000000D);
        address = 2'd3;
        step();
        check("cap_fall_bit1", rd[1], 32'h2);
        check("irq_before", 32'(irqv[1]), 32'h0);
        step();
        check("irq_fall_bit1", 32'(irqv[1]), 32'h1);

        do_write(2'd3, 32'h0);
        check("clear_zero_keeps", rd[1], 32'h2);
        do_write(2'd3, 32'h2);
        check("clear_bit1", rd[1], 32'h0);
        step();
        check("irq_cleared", 32'(irqv[1]), 32'h0);

        // Fall on bit0 coinciding with a clear of bit0
        in_port = 4'hC;
        step(2);
        do_write(2'd3, 32'h1);
        check("detect_beats_clear", rd[1], 32'h1);

        // Mask gating
        do_write(2'd2, 32'h0);
        in_port = 4'h8;
        address = 2'd3;
        step(3);
        check("cap_five", rd[1], 32'h5);
        step();
        check("irq_masked", 32'(irqv[1]), 32'h0);
        do_write(2'd2, 32'h4);
        step();
        check("irq_unmasked", 32'(irqv[1]), 32'h1);
        peek(2'd2);
        check("read_mask", rd[1], 32'h4);
        peek(2'd1);
        check("read_reserved", rd[1], 32'h0);
        do_write(2'd1, 32'hFFFF_FFFF);
        do_write(2'd0, 32'hFFFF_FFFF);
        peek(2'd1);
        check("reserved_write_ignored", rd[2], 32'h0);

        // Any-edge: bit3 toggles 1->0->1->0 with clears between
        in_port = 4'h0;
        step(5);
        do_write(2'd3, 32'hF);
        do_write(2'd2, 32'h8);
        in_port = 4'h8;
        address = 2'd3;
        step(5);
        check("any_rise_bit3", rd[2], 32'h8);
        do_write(2'd3, 32'hF);
        check("any_cleared", rd[2], 32'h0);
        in_port = 4'h0;
        step(5);
        check("any_fall_bit3", rd[2], 32'h8);
        check("any_irq", 32'(irqv[2]), 32'h1);
        reset = 1'b1;
        step();
        check("reset_cap", rd[2], 32'h0);
        check("reset_irq", 32'(irqv), 32'h0);
        reset = 1'b0;

        // Randomized traffic with occasional mid-run resets
        for (int i = 0; i < 400; i++) begin
            in_port    = W'($urandom);
            address    = 2'($urandom);
            writedata  = $urandom;
            chipselect = ($urandom_range(0, 9) < 4);
            write_n    = ($urandom_range(0, 9) < 5);
            reset      = ($urandom_range(0, 99) < 2);
            step();
        end
        reset      = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
